washer_sequencer: RTL and testbench
===================================

Name: washer_sequencer

Overview:
- Timed sequencer that drives the `controlEM` and `controlServo` inputs of the washer PWM stage.
- Runs complete pick-up and drop-off cycles: lower arm, energize or release the magnet, dwell, raise arm.
- Sits between the station-system command logic and the washer PWM block.
- Tracks whether a washer is currently held and rejects commands that are illegal in that state.

Parameters:
- TICK_DIV, 50000: CLK cycles per timing tick (1 ms at 50 MHz); legal range 1..65535.
- SERVO_TICKS, 500: ticks spent in each arm-motion phase (LOWER, RAISE); 0 is treated as 1.
- DWELL_TICKS, 200: ticks spent in the magnet phase (ENERGIZE, RELEASE); 0 is treated as 1.
- TW, 16: width of the tick and phase counters.

Ports:
- CLK, input, 1: system clock; all state updates on posedge.
- RST, input, 1: asynchronous, active-high reset.
- start, input, 1: command strobe, sampled only in IDLE.
- cmd_pick, input, 1: command select, sampled with start; 1 = pick up, 0 = drop.
- controlEM, output, 1: magnet request to the PWM stage; 1 = magnet on.
- controlServo, output, 1: arm request to the PWM stage; 1 = up, 0 = down.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse when a cycle completes.
- err, output, 1: one-cycle pulse when a command is rejected.
- holding, output, 1: 1 while a washer is on the magnet.

Behaviour:
- Reset values: controlEM=0, controlServo=1, busy=0, done=0, err=0, holding=0; state=IDLE; both counters 0.
- All outputs are registered.
- States: IDLE, LOWER, ENERGIZE, RELEASE, RAISE, DONE.
- IDLE:
  - controlServo=1; controlEM=holding.
  - start=1, cmd_pick=1, holding=0 -> LOWER, phase path = pick.
  - start=1, cmd_pick=0, holding=1 -> LOWER, phase path = drop.
  - start=1 with any other combination -> err=1 for one cycle; stay in IDLE.
- LOWER: controlServo=0; controlEM unchanged.
  - After SERVO_TICKS -> ENERGIZE (pick path) or RELEASE (drop path).
- ENERGIZE: controlEM=1.
  - After DWELL_TICKS: holding<=1, -> RAISE.
- RELEASE: controlEM=0.
  - After DWELL_TICKS: holding<=0, -> RAISE.
- RAISE: controlServo=1.
  - After SERVO_TICKS -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE.
- Timing:
  - The prescaler counts 0..TICK_DIV-1 and emits a tick on wrap.
  - The phase counter counts ticks.
  - Both counters clear on every state entry.
  - Each timed phase lasts exactly N*TICK_DIV CLK cycles, where N is SERVO_TICKS or DWELL_TICKS.
- Latency: start is sampled at posedge k; busy and the new control outputs are valid after posedge k.
- start is ignored while busy=1. A held-high start re-triggers only after returning to IDLE, and only if legal.
- Reset mid-cycle forces the reset values immediately: magnet drops, arm goes up, holding clears.
- The magnet must never turn off between ENERGIZE and the next RELEASE, including across IDLE.

Optional Feature:
- Macro: WASHER_SEQ_ABORT_EN.
- Defined:
  - Adds port `abort` (input, 1).
  - abort=1 in LOWER, ENERGIZE or RELEASE -> RAISE next cycle, with controlEM<=holding (the magnet state is preserved).
  - On RAISE completion the block goes to IDLE with err=1 instead of done.
  - abort is ignored in IDLE, RAISE and DONE.
- Undefined: no abort port; every sequence always runs to completion.

Decomposition:
- Shared package `washer_pkg`:
  - State enum seq_state_t.
  - Constants SERVO_UP=1'b1 and SERVO_DOWN=1'b0.
  - Default tick constants.
- Sub-module `washer_tick_timer`:
  - Prescaler plus phase counter.
  - Inputs: clr, len.
  - Output: expired, a one-cycle pulse when the phase counter reaches len.

Test Plan:
- Reset check (TICK_DIV=4, SERVO_TICKS=3, DWELL_TICKS=2 throughout):
  - Assert RST mid-clock -> controlEM=0, controlServo=1, busy=0, holding=0 without waiting for a clock edge.
- Pick cycle:
  - Stimulus: start, cmd_pick=1.
  - Response: LOWER for 12 cycles, ENERGIZE for 8, RAISE for 12, then done pulse.
  - Afterwards: holding=1, controlEM=1, controlServo=1.
- Drop cycle, after a pick:
  - Stimulus: start, cmd_pick=0.
  - Response: controlEM stays 1 through LOWER and goes 0 at RELEASE entry; done after 33 cycles; holding=0.
- Illegal commands:
  - Drop with holding=0 -> err pulse, busy stays 0.
  - Pick with holding=1 -> err pulse, busy stays 0.
- start held high for the whole pick cycle -> no extra cycle starts; the next attempt is an illegal pick, giving an err pulse.
- WASHER_SEQ_ABORT_EN defined:
  - Stimulus: abort during ENERGIZE of a pick.
  - Response: RAISE next cycle; err after 12 cycles; done never pulses; holding=0; controlEM=0.

Source files
------------

// File: rtl/washer_pkg.sv
// Shared types and constants for the washer pick/drop sequencer.
package washer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOWER,
    ST_ENERGIZE,
    ST_RELEASE,
    ST_RAISE,
    ST_DONE
  } seq_state_t;

  typedef enum logic {
    PATH_PICK,
    PATH_DROP
  } path_t;

  localparam logic SERVO_UP   = 1'b1;
  localparam logic SERVO_DOWN = 1'b0;

  localparam int unsigned DEF_TICK_DIV    = 50000;
  localparam int unsigned DEF_SERVO_TICKS = 500;
  localparam int unsigned DEF_DWELL_TICKS = 200;
  localparam int unsigned DEF_TW          = 16;

  // A phase length of zero would never expire; treat it as one tick.
  function automatic int unsigned eff_ticks(input int unsigned n);
    return (n == 0) ? 1 : n;
  endfunction

endpackage

// File: rtl/washer_sequencer_if.sv
// Command/status bundle between station logic (master) and the sequencer (slave).
// Optional abort input when WASHER_SEQ_ABORT_EN is defined.
interface washer_sequencer_if;

  logic start;
  logic cmd_pick;
`ifdef WASHER_SEQ_ABORT_EN
  logic abort;
`endif
  logic controlEM;
  logic controlServo;
  logic busy;
  logic done;
  logic err;
  logic holding;

`ifdef WASHER_SEQ_ABORT_EN
  modport master (output start, cmd_pick, abort,
                  input  controlEM, controlServo, busy, done, err, holding);
  modport slave  (input  start, cmd_pick, abort,
                  output controlEM, controlServo, busy, done, err, holding);
`else
  modport master (output start, cmd_pick,
                  input  controlEM, controlServo, busy, done, err, holding);
  modport slave  (input  start, cmd_pick,
                  output controlEM, controlServo, busy, done, err, holding);
`endif

endinterface

// File: rtl/washer_tick_timer.sv
// Prescaler plus phase counter; expired pulses in the last CLK cycle of a
// phase of len ticks, so the FSM leaves on exactly len*TICK_DIV cycles.
module washer_tick_timer #(
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned TW       = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          clr,
  input  logic [TW-1:0] len,
  output logic          expired
);

  logic [TW-1:0] r_presc;
  logic [TW-1:0] r_phase;
  logic          w_tick;

  assign w_tick  = (r_presc == TW'(TICK_DIV - 1));
  assign expired = w_tick && (r_phase == (len - TW'(1)));

  // Prescaler wraps at TICK_DIV-1 and advances the phase counter on wrap.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_presc <= '0;
      r_phase <= '0;
    end else if (clr) begin
      r_presc <= '0;
      r_phase <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
      r_phase <= r_phase + TW'(1);
    end else begin
      r_presc <= r_presc + TW'(1);
    end
  end

endmodule

// File: rtl/washer_sequencer.sv
// Timed pick-up / drop-off sequencer driving controlEM and controlServo of
// the washer PWM stage. Optional abort: WASHER_SEQ_ABORT_EN.
module washer_sequencer
  import washer_pkg::*;
#(
  parameter int unsigned TICK_DIV    = DEF_TICK_DIV,
  parameter int unsigned SERVO_TICKS = DEF_SERVO_TICKS,
  parameter int unsigned DWELL_TICKS = DEF_DWELL_TICKS,
  parameter int unsigned TW          = DEF_TW
) (
  input  logic              CLK,
  input  logic              RST,
  washer_sequencer_if.slave bus
);

  localparam logic [TW-1:0] SERVO_LEN = TW'(eff_ticks(SERVO_TICKS));
  localparam logic [TW-1:0] DWELL_LEN = TW'(eff_ticks(DWELL_TICKS));

  seq_state_t    r_state, w_state_next;
  path_t         r_path, w_path_next;
  logic          r_em, w_em_next;
  logic          r_servo, w_servo_next;
  logic          r_busy, w_busy_next;
  logic          r_done, w_done_next;
  logic          r_err, w_err_next;
  logic          r_hold, w_hold_next;
  logic          r_aborted, w_aborted_next;

  logic          w_abort;
  logic          w_expired;
  logic          w_clr;
  logic [TW-1:0] w_len;

`ifdef WASHER_SEQ_ABORT_EN
  assign w_abort = bus.abort;
`else
  assign w_abort = 1'b0;
`endif

  // Arm-motion phases use the servo length, magnet phases the dwell length.
  always_comb begin
    w_len = DWELL_LEN;
    if ((r_state == ST_LOWER) || (r_state == ST_RAISE)) begin
      w_len = SERVO_LEN;
    end
  end

  // Counters restart on every state entry and are held clear while idle.
  assign w_clr = (w_state_next != r_state) || (r_state == ST_IDLE);

  washer_tick_timer #(
    .TICK_DIV (TICK_DIV),
    .TW       (TW)
  ) u_timer (
    .CLK     (CLK),
    .RST     (RST),
    .clr     (w_clr),
    .len     (w_len),
    .expired (w_expired)
  );

  // State and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_path    <= PATH_PICK;
      r_em      <= 1'b0;
      r_servo   <= SERVO_UP;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_hold    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_path    <= w_path_next;
      r_em      <= w_em_next;
      r_servo   <= w_servo_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
      r_err     <= w_err_next;
      r_hold    <= w_hold_next;
      r_aborted <= w_aborted_next;
    end
  end

  // Next state and next output values; outputs reflect the state being entered.
  always_comb begin
    w_state_next   = r_state;
    w_path_next    = r_path;
    w_em_next      = r_em;
    w_servo_next   = r_servo;
    w_busy_next    = r_busy;
    w_done_next    = 1'b0;
    w_err_next     = 1'b0;
    w_hold_next    = r_hold;
    w_aborted_next = r_aborted;

    unique case (r_state)
      ST_IDLE: begin
        w_servo_next = SERVO_UP;
        w_em_next    = r_hold;
        w_busy_next  = 1'b0;
        if (bus.start) begin
          if (bus.cmd_pick && !r_hold) begin
            w_state_next   = ST_LOWER;
            w_path_next    = PATH_PICK;
            w_servo_next   = SERVO_DOWN;
            w_busy_next    = 1'b1;
            w_aborted_next = 1'b0;
          end else if (!bus.cmd_pick && r_hold) begin
            w_state_next   = ST_LOWER;
            w_path_next    = PATH_DROP;
            w_servo_next   = SERVO_DOWN;
            w_busy_next    = 1'b1;
            w_aborted_next = 1'b0;
          end else begin
            w_err_next = 1'b1;
          end
        end
      end

      ST_LOWER: begin
        if (w_abort) begin
          w_state_next   = ST_RAISE;
          w_servo_next   = SERVO_UP;
          w_em_next      = r_hold;
          w_aborted_next = 1'b1;
        end else if (w_expired) begin
          if (r_path == PATH_PICK) begin
            w_state_next = ST_ENERGIZE;
            w_em_next    = 1'b1;
          end else begin
            w_state_next = ST_RELEASE;
            w_em_next    = 1'b0;
          end
        end
      end

      ST_ENERGIZE: begin
        if (w_abort) begin
          w_state_next   = ST_RAISE;
          w_servo_next   = SERVO_UP;
          w_em_next      = r_hold;
          w_aborted_next = 1'b1;
        end else if (w_expired) begin
          w_state_next = ST_RAISE;
          w_servo_next = SERVO_UP;
          w_hold_next  = 1'b1;
        end
      end

      ST_RELEASE: begin
        if (w_abort) begin
          w_state_next   = ST_RAISE;
          w_servo_next   = SERVO_UP;
          w_em_next      = r_hold;
          w_aborted_next = 1'b1;
        end else if (w_expired) begin
          w_state_next = ST_RAISE;
          w_servo_next = SERVO_UP;
          w_hold_next  = 1'b0;
        end
      end

      ST_RAISE: begin
        if (w_expired) begin
          if (r_aborted) begin
            w_state_next   = ST_IDLE;
            w_busy_next    = 1'b0;
            w_err_next     = 1'b1;
            w_em_next      = r_hold;
            w_aborted_next = 1'b0;
          end else begin
            w_state_next = ST_DONE;
            w_done_next  = 1'b1;
          end
        end
      end

      ST_DONE: begin
        w_state_next = ST_IDLE;
        w_busy_next  = 1'b0;
        w_servo_next = SERVO_UP;
        w_em_next    = r_hold;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.controlEM    = r_em;
  assign bus.controlServo = r_servo;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.err          = r_err;
  assign bus.holding      = r_hold;

endmodule

// File: tb/tb_washer_sequencer.sv
// Directed bench for washer_sequencer with TICK_DIV=4, SERVO_TICKS=3, DWELL_TICKS=2.
// Cycle index n=1 is the first sample after the edge that takes start.
module tb_washer_sequencer;

  logic CLK;
  logic RST;
  int   checks;
  int   failures;

  washer_sequencer_if bus();

  washer_sequencer #(
    .TICK_DIV    (4),
    .SERVO_TICKS (3),
    .DWELL_TICKS (2),
    .TW          (16)
  ) u_dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Follows one sequence from the start edge until busy drops, recording event times.
  task automatic run_seq(input logic keep_start,
                         output int t_em_on, output int t_em_off, output int t_up,
                         output int t_done, output int n_done, output int n_err,
                         output int t_end, output logic first_busy,
                         output logic first_servo, output logic first_em);
    logic prev_em;
    logic prev_servo;
    t_em_on = 0; t_em_off = 0; t_up = 0; t_done = 0;
    n_done = 0; n_err = 0; t_end = 0;
    first_busy = 1'b0; first_servo = 1'b0; first_em = 1'b0;
    prev_em    = bus.controlEM;
    prev_servo = bus.controlServo;
    for (int n = 1; n <= 200; n++) begin
      step();
      if (n == 1) begin
        if (!keep_start) bus.start = 1'b0;
        first_busy  = bus.busy;
        first_servo = bus.controlServo;
        first_em    = bus.controlEM;
      end
      if (bus.controlEM && !prev_em && t_em_on == 0) t_em_on = n;
      if (!bus.controlEM && prev_em && t_em_off == 0) t_em_off = n;
      if (bus.controlServo && !prev_servo && t_up == 0) t_up = n;
      prev_em    = bus.controlEM;
      prev_servo = bus.controlServo;
      if (bus.done) begin
        n_done++;
        if (t_done == 0) t_done = n;
      end
      if (bus.err) n_err++;
      if (!bus.busy) begin
        t_end = n;
        break;
      end
    end
    if (t_end == 0) check("seq_timeout", 0, 1);
  endtask

  int   t_em_on, t_em_off, t_up, t_done, n_done, n_err, t_end;
  logic f_busy, f_servo, f_em;

  initial begin
    checks   = 0;
    failures = 0;
    bus.start    = 1'b0;
    bus.cmd_pick = 1'b0;
`ifdef WASHER_SEQ_ABORT_EN
    bus.abort    = 1'b0;
`endif
    RST = 1'b1;
    #3;
    check("rst_em",      bus.controlEM,    0);
    check("rst_servo",   bus.controlServo, 1);
    check("rst_busy",    bus.busy,         0);
    check("rst_done",    bus.done,         0);
    check("rst_err",     bus.err,          0);
    check("rst_holding", bus.holding,      0);
    step();
    step();
    RST = 1'b0;
    step();

    // Drop while empty is illegal.
    bus.start = 1'b1; bus.cmd_pick = 1'b0;
    step();
    bus.start = 1'b0;
    check("ill_drop_err",  bus.err,  1);
    check("ill_drop_busy", bus.busy, 0);
    step();
    check("ill_drop_err_pulse", bus.err, 0);

    // Pick cycle: LOWER n=1..12, ENERGIZE 13..20, RAISE 21..32, DONE 33.
    bus.start = 1'b1; bus.cmd_pick = 1'b1;
    run_seq(1'b0, t_em_on, t_em_off, t_up, t_done, n_done, n_err, t_end, f_busy, f_servo, f_em);
    check("pick_busy_n1",  f_busy,  1);
    check("pick_servo_n1", f_servo, 0);
    check("pick_em_on",    t_em_on, 13);
    check("pick_up",       t_up,    21);
    check("pick_done_t",   t_done,  33);
    check("pick_done_n",   n_done,  1);
    check("pick_err_n",    n_err,   0);
    check("pick_end",      t_end,   34);
    check("pick_holding",  bus.holding,      1);
    check("pick_em_after", bus.controlEM,    1);
    check("pick_servo_after", bus.controlServo, 1);

    // Pick while holding is illegal; magnet stays on.
    bus.start = 1'b1; bus.cmd_pick = 1'b1;
    step();
    bus.start = 1'b0;
    check("ill_pick_err",  bus.err,       1);
    check("ill_pick_busy", bus.busy,      0);
    check("ill_pick_em",   bus.controlEM, 1);

    // Drop cycle: magnet on through LOWER, off at RELEASE entry.
    step();
    bus.start = 1'b1; bus.cmd_pick = 1'b0;
    run_seq(1'b0, t_em_on, t_em_off, t_up, t_done, n_done, n_err, t_end, f_busy, f_servo, f_em);
    check("drop_em_n1",   f_em,     1);
    check("drop_em_off",  t_em_off, 13);
    check("drop_up",      t_up,     21);
    check("drop_done_t",  t_done,   33);
    check("drop_done_n",  n_done,   1);
    check("drop_holding", bus.holding,   0);
    check("drop_em_after", bus.controlEM, 0);

    // start held high through a whole pick: no retrigger, then illegal pick.
    bus.start = 1'b1; bus.cmd_pick = 1'b1;
    run_seq(1'b1, t_em_on, t_em_off, t_up, t_done, n_done, n_err, t_end, f_busy, f_servo, f_em);
    check("held_done_t", t_done, 33);
    check("held_done_n", n_done, 1);
    check("held_err_n",  n_err,  0);
    check("held_end",    t_end,  34);
    step();
    check("held_ill_err",  bus.err,  1);
    check("held_ill_busy", bus.busy, 0);
    bus.start = 1'b0;
    step();
    check("held_err_pulse", bus.err, 0);

    // Reset in the middle of a drop's LOWER phase, between clock edges.
    bus.start = 1'b1; bus.cmd_pick = 1'b0;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("mid_pre_busy", bus.busy,      1);
    check("mid_pre_em",   bus.controlEM, 1);
    #2 RST = 1'b1;
    #1;
    check("mid_rst_em",      bus.controlEM,    0);
    check("mid_rst_servo",   bus.controlServo, 1);
    check("mid_rst_busy",    bus.busy,         0);
    check("mid_rst_holding", bus.holding,      0);
    step();
    RST = 1'b0;
    step();

`ifdef WASHER_SEQ_ABORT_EN
    // Abort sampled in ENERGIZE (n=15): RAISE from n=16, err at n=28.
    bus.start = 1'b1; bus.cmd_pick = 1'b1;
    step();
    bus.start = 1'b0;
    for (int n = 2; n <= 15; n++) step();
    check("abort_pre_em", bus.controlEM, 1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("abort_raise_servo", bus.controlServo, 1);
    check("abort_raise_em",    bus.controlEM,    0);
    check("abort_raise_busy",  bus.busy,         1);
    begin
      int t_err;
      int nd;
      t_err = 0;
      nd    = 0;
      for (int n = 17; n <= 60; n++) begin
        step();
        if (bus.done) nd++;
        if (bus.err && t_err == 0) begin
          t_err = n;
          break;
        end
      end
      check("abort_err_t",  t_err, 28);
      check("abort_done_n", nd,    0);
    end
    check("abort_busy",    bus.busy,      0);
    check("abort_holding", bus.holding,   0);
    check("abort_em",      bus.controlEM, 0);
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
